// File: rtl/beaver32rv_trace_pkg.sv
// rtl/beaver32rv_trace_pkg.sv - retirement record type, packet constants and byte selector
package beaver32rv_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } commit_rec_t;

  localparam int PKT_BYTES = 14;
  localparam int LAST_IDX  = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } trace_state_e;

  // Little-endian field layout behind the sync byte.
  function automatic logic [7:0] pkt_byte(input commit_rec_t r, input logic [3:0] idx,
                                          input logic [7:0] sync);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:  b = sync;
      4'd1:  b = r.pc[7:0];
      4'd2:  b = r.pc[15:8];
      4'd3:  b = r.pc[23:16];
      4'd4:  b = r.pc[31:24];
      4'd5:  b = r.insn[7:0];
      4'd6:  b = r.insn[15:8];
      4'd7:  b = r.insn[23:16];
      4'd8:  b = r.insn[31:24];
      4'd9:  b = {r.we, 2'b00, r.rd};
      4'd10: b = r.wdata[7:0];
      4'd11: b = r.wdata[15:8];
      4'd12: b = r.wdata[23:16];
      4'd13: b = r.wdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO with occupancy count
module trace_fifo
  import beaver32rv_trace_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = commit_rec_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally; count carries the extra bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_tx.sv
// rtl/retire_trace_tx.sv - captures retirement records and serialises them as 14-byte packets
module retire_trace_tx
  import beaver32rv_trace_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         DROP_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  logic                   commit_valid,
  input  logic [31:0]            commit_pc,
  input  logic [31:0]            commit_insn,
  input  logic                   commit_we,
  input  logic [4:0]             commit_rd,
  input  logic [31:0]            commit_wdata,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_last,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [DROP_W-1:0]      drop_count
);

  commit_rec_t  rec_in;
  commit_rec_t  fifo_dout;
  commit_rec_t  hold_q;
  logic         fifo_full;
  logic         fifo_empty;
  logic         push;
  logic         drop;
  logic         pop;
  trace_state_e state_q;
  trace_state_e state_d;
  logic [3:0]   idx_q;
  logic [3:0]   idx_d;
  logic         at_last;

  assign rec_in = '{pc: commit_pc, insn: commit_insn, we: commit_we,
                    rd: commit_rd, wdata: commit_wdata};
  assign push   = commit_valid && trace_en && !fifo_full;
  assign drop   = commit_valid && trace_en && fifo_full;

  trace_fifo #(.DEPTH(DEPTH), .T(commit_rec_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rec_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign at_last = (idx_q == 4'(LAST_IDX));

  // Every pop loads the hold register and restarts the byte index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) hold_q <= fifo_dout;
      if (drop && (drop_count != {DROP_W{1'b1}})) drop_count <= drop_count + 1'b1;
    end
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? pkt_byte(hold_q, idx_q, SYNC_BYTE) : 8'h00;
  assign tx_last  = tx_valid && at_last;

endmodule

// File: tb/tb_retire_trace_tx.sv
// tb/tb_retire_trace_tx.sv - scoreboard bench for retire_trace_tx with a queue-level reference model
module tb_retire_trace_tx;
  import beaver32rv_trace_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trace_en = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] commit_insn = '0;
  logic        commit_we = 1'b0;
  logic [4:0]  commit_rd = '0;
  logic [31:0] commit_wdata = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  logic        rst2 = 1'b0;
  logic        en2 = 1'b0;
  logic        ready2 = 1'b0;
  logic        v2;
  logic [7:0]  d2;
  logic        l2;
  logic [2:0]  lvl2;
  logic [3:0]  dc2;

  retire_trace_tx #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_insn(commit_insn), .commit_we(commit_we),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  retire_trace_tx #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .DROP_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .trace_en(en2), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_insn(commit_insn), .commit_we(commit_we),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .tx_valid(v2),
    .tx_data(d2), .tx_last(l2), .tx_ready(ready2),
    .fifo_level(lvl2), .drop_count(dc2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: records waiting, bytes left of the packet in flight, drop tally.
  commit_rec_t mq [$];
  logic [8:0]  exp_q [$];
  int          rem = 0;
  int          mdrops = 0;
  commit_rec_t mrec;
  bit          m_full;
  bit          m_hs;

  function automatic logic [7:0] mbyte(input commit_rec_t r, input int i);
    if (i == 0) return 8'hA5;
    if (i <= 4) return 8'(r.pc >> (8 * (i - 1)));
    if (i <= 8) return 8'(r.insn >> (8 * (i - 5)));
    if (i == 9) return 8'(r.we * 128 + r.rd);
    return 8'(r.wdata >> (8 * (i - 10)));
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      rem = 0;
      mdrops = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_hs   = (rem > 0) && tx_ready;
      if (((rem == 0) || (m_hs && rem == 1)) && mq.size() > 0) begin
        void'(mq.pop_front());
        rem = PKT_BYTES;
      end else if (m_hs) begin
        rem--;
      end
      if (commit_valid && trace_en) begin
        if (m_full) begin
          if (mdrops < 65535) mdrops++;
        end else begin
          mrec = '{pc: commit_pc, insn: commit_insn, we: commit_we,
                   rd: commit_rd, wdata: commit_wdata};
          mq.push_back(mrec);
          for (int i = 0; i < PKT_BYTES; i++) exp_q.push_back({(i == LAST_IDX), mbyte(mrec, i)});
        end
      end
    end
  end

  // Monitor: compares every handshake and the visible state against the model.
  logic [7:0] log_q [$];
  int         log_cyc [$];
  int         pkt_cnt = 0;
  int         cyc_n = 0;
  bit         stall_prev = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  logic [8:0] e;

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      chk("tx_valid", tx_valid, (rem > 0));
      chk("fifo_level", fifo_level, mq.size());
      chk("drop_count", drop_count, mdrops);
      if (stall_prev) begin
        chk("stall_valid", tx_valid, 1'b1);
        chk("stall_data", tx_data, prev_data);
        chk("stall_last", tx_last, prev_last);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", tx_data, 9'h1FF);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e[7:0]);
          chk("tx_last", tx_last, e[8]);
        end
        log_q.push_back(tx_data);
        log_cyc.push_back(cyc_n);
        if (tx_last) pkt_cnt++;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                            input logic we, input logic [4:0] rd, input logic [31:0] wd);
    commit_valid = v;
    commit_pc    = pc;
    commit_insn  = insn;
    commit_we    = we;
    commit_rd    = rd;
    commit_wdata = wd;
  endtask

  task automatic drain();
    int n;
    commit_valid = 1'b0;
    tx_ready = 1'b1;
    n = 0;
    while ((mq.size() != 0 || rem != 0) && n < 500) begin
      cyc();
      n++;
    end
    cyc();
    chk("drain_timeout", (n < 500), 1'b1);
    chk("exp_empty", exp_q.size(), 0);
  endtask

  logic [7:0] t1 [14];

  initial begin
    t1 = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50,
           8'h00, 8'h81, 8'h05, 8'h00, 8'h00, 8'h00};

    cyc(); cyc();
    rst = 1'b1;
    rst2 = 1'b1;
    trace_en = 1'b1;
    @(negedge clk);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_last", tx_last, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drops", drop_count, 0);

    // Single commit, latency and exact byte image
    cyc();
    tx_ready = 1'b1;
    log_q.delete();
    set_commit(1'b1, 32'h10, 32'h00500093, 1'b1, 5'd1, 32'd5);
    @(negedge clk);
    chk("lat_n", tx_valid, 1'b0);
    cyc();
    commit_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1", tx_valid, 1'b0);
    cyc();
    @(negedge clk);
    chk("lat_n2_valid", tx_valid, 1'b1);
    chk("lat_n2_data", tx_data, 8'hA5);
    drain();
    chk("t1_len", log_q.size(), 14);
    for (int i = 0; i < 14 && i < log_q.size(); i++) chk($sformatf("t1_b%0d", i), log_q[i], t1[i]);

    // Backpressure 1,0,0,1
    log_q.delete();
    set_commit(1'b1, 32'h10, 32'h00500093, 1'b1, 5'd1, 32'd5);
    for (int i = 0; i < 80 && log_q.size() < 14; i++) begin
      tx_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc();
      commit_valid = 1'b0;
    end
    drain();
    chk("t2_len", log_q.size(), 14);
    for (int i = 0; i < 14 && i < log_q.size(); i++) chk($sformatf("t2_b%0d", i), log_q[i], t1[i]);

    // Overflow with the sink stalled
    log_q.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_commit(1'b1, 32'(4 * i), 32'h13 + 32'(i), i[0], 5'(i + 3), 32'(100 + i));
      cyc();
    end
    commit_valid = 1'b0;
    @(negedge clk);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_drops", drop_count, 3);
    chk("ovf_hold_valid", tx_valid, 1'b1);
    pkt_cnt = 0;
    drain();
    chk("ovf_pkts", pkt_cnt, 5);
    chk("ovf_len", log_q.size(), 70);
    for (int k = 0; k < 5 && log_q.size() == 70; k++)
      chk($sformatf("ovf_pc%0d", k),
          {log_q[14*k+4], log_q[14*k+3], log_q[14*k+2], log_q[14*k+1]}, 32'(4 * k));

    // Back-to-back packets
    log_q.delete();
    log_cyc.delete();
    tx_ready = 1'b1;
    set_commit(1'b1, 32'h200, 32'hAA, 1'b0, 5'd9, 32'hDEADBEEF);
    cyc();
    set_commit(1'b1, 32'h204, 32'hBB, 1'b1, 5'd31, 32'h12345678);
    cyc();
    drain();
    chk("b2b_len", log_q.size(), 28);
    if (log_q.size() == 28) begin
      chk("b2b_gap", log_cyc[14] - log_cyc[13], 1);
      chk("b2b_sync", log_q[14], 8'hA5);
    end

    // Reset mid-packet
    log_q.delete();
    set_commit(1'b1, 32'h300, 32'hCC, 1'b1, 5'd4, 32'h77);
    cyc();
    commit_valid = 1'b0;
    for (int i = 0; i < 40 && log_q.size() < 6; i++) cyc();
    chk("mid_reached", (log_q.size() >= 6), 1'b1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid", tx_valid, 1'b0);
    chk("mid_level", fifo_level, 0);
    chk("mid_drops", drop_count, 0);
    log_q.delete();
    cyc();
    set_commit(1'b1, 32'h400, 32'hDD, 1'b0, 5'd2, 32'h88);
    cyc();
    drain();
    chk("post_len", log_q.size(), 14);
    if (log_q.size() > 0) chk("post_sync", log_q[0], 8'hA5);

    // Tracing disabled
    pkt_cnt = 0;
    trace_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_commit(1'b1, 32'(i), 32'h1, 1'b1, 5'd1, 32'h1);
      cyc();
    end
    commit_valid = 1'b0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("dis_pkts", pkt_cnt, 0);
    chk("dis_drops", drop_count, 0);

    // Saturating counter on the narrow instance
    en2 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      set_commit(1'b1, 32'(i), 32'h2, 1'b0, 5'd0, 32'h0);
      cyc();
      if (i == 14) begin
        @(negedge clk);
        chk("sat_mid", dc2, 4'd10);
      end
    end
    commit_valid = 1'b0;
    en2 = 1'b0;
    @(negedge clk);
    chk("sat_full", dc2, 4'd15);
    chk("sat_level", lvl2, 4);
    chk("sat_valid", v2, 1'b1);
    trace_en = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      set_commit(($urandom % 3) != 0, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom);
      trace_en = ($urandom % 8) != 0;
      tx_ready = ($urandom % 3) != 0;
      rst      = ($urandom % 300) != 0;
      cyc();
    end
    rst = 1'b1;
    trace_en = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
